// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset core: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB over one shared req/ack memory port and counts retirements.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        Zero,
  input  logic        MemAck,
  output logic        MemReq,
  output logic        MemWe,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  WBSrc,
  output logic        ALUsrc,
  output logic [2:0]  ALUop,
  output logic        ExtRes,
  output logic        Retire,
  output logic [31:0] InstrCnt
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [3:0] {
    I_NOP, I_ADD, I_SUB, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL
  } instr_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  localparam logic [1:0] PC_INC = 2'b00, PC_BR = 2'b01, PC_JAL = 2'b10, PC_REG = 2'b11;
  localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00, WB_MDR = 2'b01, WB_LUI = 2'b10, WB_PC = 2'b11;

  state_t state, stateNext;
  instr_t instr;

  // Anything not recognised (including the R-type nop) collapses to I_NOP.
  always_comb begin
    instr = I_NOP;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  instr = I_ADD;
          FN_SUB:  instr = I_SUB;
          FN_JR:   instr = I_JR;
          default: instr = I_NOP;
        endcase
      end
      OP_JAL:  instr = I_JAL;
      OP_BEQ:  instr = I_BEQ;
      OP_ORI:  instr = I_ORI;
      OP_LUI:  instr = I_LUI;
      OP_LW:   instr = I_LW;
      OP_SW:   instr = I_SW;
      default: instr = I_NOP;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    stateNext = state;
    MemReq    = 1'b0;
    MemWe     = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = PC_INC;
    RegWrite  = 1'b0;
    RegDst    = DST_RT;
    WBSrc     = WB_ALU;
    Retire    = 1'b0;
    ALUsrc    = 1'b0;
    ALUop     = 3'b000;
    ExtRes    = 1'b0;

    case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        MemReq = 1'b1;
        if (MemAck) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          PCSrc     = PC_INC;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        case (instr)
          I_JAL: begin
            PCWrite  = 1'b1;
            PCSrc    = PC_JAL;
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            WBSrc    = WB_PC;
            Retire   = 1'b1;
            stateNext = FETCH;
          end
          I_JR: begin
            PCWrite   = 1'b1;
            PCSrc     = PC_REG;
            Retire    = 1'b1;
            stateNext = FETCH;
          end
          I_LUI: begin
            RegWrite  = 1'b1;
            RegDst    = DST_RT;
            WBSrc     = WB_LUI;
            Retire    = 1'b1;
            stateNext = FETCH;
          end
          I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ: stateNext = EXEC;
          default: begin
            Retire    = 1'b1;
            stateNext = FETCH;
          end
        endcase
      end
      EXEC: begin
        case (instr)
          I_BEQ: begin
            PCWrite   = Zero;
            PCSrc     = PC_BR;
            Retire    = 1'b1;
            stateNext = FETCH;
          end
          I_ADD, I_SUB, I_ORI: stateNext = WB;
          I_LW, I_SW:          stateNext = MEM;
          default: begin
            Retire    = 1'b1;
            stateNext = FETCH;
          end
        endcase
      end
      MEM: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        MemWe  = (instr == I_SW);
        if (MemAck) begin
          if (instr == I_SW) begin
            Retire    = 1'b1;
            stateNext = FETCH;
          end else begin
            stateNext = WB;
          end
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        Retire    = 1'b1;
        stateNext = FETCH;
        case (instr)
          I_ADD, I_SUB: RegDst = DST_RD;
          I_LW:         WBSrc  = WB_MDR;
          default:      RegDst = DST_RT;
        endcase
      end
      default: stateNext = IDLE;
    endcase

    case (instr)
      I_SUB, I_BEQ: ALUop = 3'b001;
      I_ORI:        ALUop = 3'b011;
      default:      ALUop = 3'b000;
    endcase
    ALUsrc = (instr == I_ORI) || (instr == I_LW) || (instr == I_SW);
    ExtRes = (instr == I_ORI);

    // Outputs are combinational, so an in-flight request must be squashed the moment reset asserts.
    if (!reset_n) begin
      MemReq   = 1'b0;
      MemWe    = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'b00;
      RegWrite = 1'b0;
      RegDst   = 2'b00;
      WBSrc    = 2'b00;
      Retire   = 1'b0;
      ALUsrc   = 1'b0;
      ALUop    = 3'b000;
      ExtRes   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      InstrCnt <= '0;
    end else begin
      state <= stateNext;
      if (Retire) InstrCnt <= InstrCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction step-script model derived from the
// instruction behaviour table, driven with random instruction mix and random memory wait states.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  op, func;
  logic        Zero, MemAck;
  logic        MemReq, MemWe, IorD, IRWrite, PCWrite, RegWrite, ALUsrc, ExtRes, Retire;
  logic [1:0]  PCSrc, RegDst, WBSrc;
  logic [2:0]  ALUop;
  logic [31:0] InstrCnt;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .func(func), .Zero(Zero), .MemAck(MemAck),
    .MemReq(MemReq), .MemWe(MemWe), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst), .WBSrc(WBSrc), .ALUsrc(ALUsrc),
    .ALUop(ALUop), .ExtRes(ExtRes), .Retire(Retire), .InstrCnt(InstrCnt)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NOP, K_ADD, K_SUB, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_ILL} kind_t;

  typedef struct packed {
    logic       memReq, memWe, iorD, irWrite, pcWrite;
    logic [1:0] pcSrc;
    logic       regWrite;
    logic [1:0] regDst, wbSrc;
    logic       retire;
  } strobe_t;

  typedef struct {
    logic    ack;
    logic    zero;
    strobe_t s;
  } step_t;

  step_t       steps[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned modelCnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic strobe_t obsStrobe();
    return strobe_t'({MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst, WBSrc, Retire});
  endfunction

  // {ALUsrc, ALUop, ExtRes} as the instruction table defines them.
  function automatic logic [4:0] expAlu(kind_t k);
    case (k)
      K_SUB, K_BEQ: return {1'b0, 3'b001, 1'b0};
      K_ORI:        return {1'b1, 3'b011, 1'b1};
      K_LW, K_SW:   return {1'b1, 3'b000, 1'b0};
      default:      return 5'b0;
    endcase
  endfunction

  function automatic int expCpi(kind_t k, int fw, int mw);
    case (k)
      K_BEQ:      return 3 + fw;
      K_LW:       return 5 + fw + mw;
      K_SW:       return 4 + fw + mw;
      K_ADD, K_SUB, K_ORI: return 4 + fw;
      default:    return 2 + fw;
    endcase
  endfunction

  task automatic setInstr(kind_t k);
    func = 6'($urandom);
    case (k)
      K_NOP: begin op = 6'b000000; func = 6'b000000; end
      K_ADD: begin op = 6'b000000; func = 6'b100000; end
      K_SUB: begin op = 6'b000000; func = 6'b100010; end
      K_JR:  begin op = 6'b000000; func = 6'b001000; end
      K_ORI: op = 6'b001101;
      K_LW:  op = 6'b100011;
      K_SW:  op = 6'b101011;
      K_BEQ: op = 6'b000100;
      K_LUI: op = 6'b001111;
      K_JAL: op = 6'b000011;
      default: op = 6'b111111;
    endcase
  endtask

  // A cycle where the memory is not being asked for anything: ack and Zero are noise.
  function automatic step_t quiet();
    step_t st;
    st.ack  = 1'($urandom);
    st.zero = 1'($urandom);
    st.s    = '0;
    return st;
  endfunction

  // zsel: 0/1 forces Zero in the beq EXEC cycle, anything else leaves it random.
  task automatic buildInstr(kind_t k, int fw, int mw, int zsel);
    step_t st;
    steps.delete();
    for (int i = 0; i < fw; i++) begin
      st = quiet(); st.ack = 1'b0; st.s.memReq = 1'b1;
      steps.push_back(st);
    end
    st = quiet(); st.ack = 1'b1;
    st.s.memReq = 1'b1; st.s.irWrite = 1'b1; st.s.pcWrite = 1'b1; st.s.pcSrc = 2'b00;
    steps.push_back(st);
    st = quiet();
    case (k)
      K_JAL: begin
        st.s.pcWrite = 1'b1; st.s.pcSrc = 2'b10; st.s.regWrite = 1'b1;
        st.s.regDst = 2'b10; st.s.wbSrc = 2'b11; st.s.retire = 1'b1;
        steps.push_back(st);
      end
      K_JR: begin
        st.s.pcWrite = 1'b1; st.s.pcSrc = 2'b11; st.s.retire = 1'b1;
        steps.push_back(st);
      end
      K_LUI: begin
        st.s.regWrite = 1'b1; st.s.regDst = 2'b00; st.s.wbSrc = 2'b10; st.s.retire = 1'b1;
        steps.push_back(st);
      end
      K_BEQ: begin
        steps.push_back(st);
        st = quiet();
        if (zsel == 0 || zsel == 1) st.zero = (zsel == 1);
        st.s.pcWrite = st.zero; st.s.pcSrc = 2'b01; st.s.retire = 1'b1;
        steps.push_back(st);
      end
      K_ADD, K_SUB, K_ORI: begin
        steps.push_back(st);
        steps.push_back(quiet());
        st = quiet();
        st.s.regWrite = 1'b1; st.s.retire = 1'b1; st.s.wbSrc = 2'b00;
        st.s.regDst = (k == K_ORI) ? 2'b00 : 2'b01;
        steps.push_back(st);
      end
      K_LW, K_SW: begin
        steps.push_back(st);
        steps.push_back(quiet());
        for (int i = 0; i <= mw; i++) begin
          st = quiet();
          st.ack = (i == mw);
          st.s.memReq = 1'b1; st.s.iorD = 1'b1; st.s.memWe = (k == K_SW);
          st.s.retire = (i == mw) && (k == K_SW);
          steps.push_back(st);
        end
        if (k == K_LW) begin
          st = quiet();
          st.s.regWrite = 1'b1; st.s.regDst = 2'b00; st.s.wbSrc = 2'b01; st.s.retire = 1'b1;
          steps.push_back(st);
        end
      end
      default: begin
        st.s.retire = 1'b1;
        steps.push_back(st);
      end
    endcase
  endtask

  // Plays the script one cycle at a time; limit < 0 runs it to completion and checks the CPI.
  task automatic runSteps(kind_t k, int fw, int mw, string name, int limit);
    int retireAt = -1;
    int n = (limit < 0) ? steps.size() : limit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) setInstr(k);
      MemAck = steps[i].ack;
      Zero   = steps[i].zero;
      #1;
      check($sformatf("%s c%0d strobes", name, i), 32'(obsStrobe()), 32'(steps[i].s));
      check($sformatf("%s c%0d alu", name, i), 32'({ALUsrc, ALUop, ExtRes}), 32'(expAlu(k)));
      check($sformatf("%s c%0d instrcnt", name, i), InstrCnt, modelCnt);
      if (Retire && retireAt < 0) retireAt = i + 1;
      if (steps[i].s.retire) modelCnt++;
    end
    if (limit < 0) check($sformatf("%s cpi", name), 32'(retireAt), 32'(expCpi(k, fw, mw)));
  endtask

  task automatic runInstr(kind_t k, int fw, int mw, int zsel, string name);
    buildInstr(k, fw, mw, zsel);
    runSteps(k, fw, mw, name, -1);
  endtask

  task automatic checkReset(string name);
    check({name, " strobes"}, 32'(obsStrobe()), 32'h0);
    check({name, " alu"}, 32'({ALUsrc, ALUop, ExtRes}), 32'h0);
    check({name, " instrcnt"}, InstrCnt, 32'h0);
  endtask

  task automatic checkIdle(kind_t k, string name);
    check({name, " strobes"}, 32'(obsStrobe()), 32'h0);
    check({name, " alu"}, 32'({ALUsrc, ALUop, ExtRes}), 32'(expAlu(k)));
    check({name, " instrcnt"}, InstrCnt, modelCnt);
  endtask

  initial begin
    kind_t k;
    int fw, mw;

    reset_n = 1'b0;
    setInstr(K_ORI);
    MemAck = 1'b1;
    Zero   = 1'b1;
    @(negedge clk); #1;
    checkReset("in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    modelCnt = 0;
    checkIdle(K_ORI, "idle_after_reset");

    runInstr(K_ORI, 0, 0, 2, "ori_zero_wait");
    runInstr(K_LW,  0, 3, 2, "lw_mem_wait3");
    runInstr(K_BEQ, 0, 0, 1, "beq_taken");
    runInstr(K_BEQ, 0, 0, 0, "beq_not_taken");
    runInstr(K_JAL, 0, 0, 2, "jal");
    runInstr(K_JR,  0, 0, 2, "jr_ra");
    runInstr(K_ILL, 0, 0, 2, "illegal_op");
    runInstr(K_SW,  2, 1, 2, "sw_waits");
    runInstr(K_NOP, 1, 0, 2, "nop_fetch_wait");

    for (int t = 0; t < 40; t++) begin
      k  = kind_t'($urandom_range(0, 10));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      runInstr(k, fw, mw, 2, $sformatf("rand%0d_%s", t, k.name()));
    end

    // Reset asserted in the middle of a stalled sw memory access.
    buildInstr(K_SW, 0, 3, 2);
    runSteps(K_SW, 0, 3, "sw_pre_reset", 5);
    @(negedge clk);
    MemAck = 1'b0;
    #1;
    check("sw_mem_req_before_reset", 32'(MemReq), 32'h1);
    reset_n = 1'b0;
    #1;
    modelCnt = 0;
    checkReset("sw_mid_mem_reset");
    @(negedge clk); #1;
    checkReset("sw_reset_held");
    reset_n = 1'b1;
    #1;
    checkIdle(K_SW, "idle_after_mid_reset");
    runInstr(K_ADD, 0, 0, 2, "add_after_reset");
    runInstr(K_LUI, 0, 0, 2, "lui_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS-subset core (add, sub, jr, nop, ori, lw, sw, beq, lui, jal). It replaces single-cycle control with an FSM that breaks each instruction into fetch/decode/execute/memory/writeback steps. It shares one unified memory port between instruction fetch and data access through a req/ack handshake. It drives per-cycle strobes to the PC, IR, register file, ALU and memory-address mux, and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]; stable from the DECODE cycle onward
- func  in  6  IR[5:0]
- Zero  in  1  ALU result == 0, valid in EXEC
- MemAck  in  1  memory completes the pending access this cycle
- MemReq  out  1  memory access request
- MemWe  out  1  1 = write (sw), 0 = read
- IorD  out  1  address select: 0 = PC, 1 = ALU result register
- IRWrite  out  1  load IR from memory read data
- PCWrite  out  1  unconditional PC load
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jal target, 11 = GPR[rs]
- RegWrite  out  1  GPR write enable
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31
- WBSrc  out  2  00 = ALU result, 01 = MDR, 10 = imm<<16, 11 = PC (already PC+4)
- ALUsrc  out  1  1 = extended immediate
- ALUop  out  3  000 = add, 001 = sub, 011 = or
- ExtRes  out  1  1 = zero-extend (ori), 0 = sign-extend
- Retire  out  1  one-cycle pulse in the final cycle of each instruction
- InstrCnt  out  32  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- Reset:
  - State = IDLE, InstrCnt = 0.
  - All outputs are 0 while reset_n is low.
  - Reset is honoured mid-access; any in-flight MemReq drops immediately.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - MemReq=1, IorD=0, MemWe=0.
  - Hold while MemAck=0.
  - On MemAck=1: IRWrite=1, PCWrite=1, PCSrc=00, then -> DECODE.
- DECODE:
  - jal: PCWrite, PCSrc=10, RegWrite, RegDst=10, WBSrc=11, Retire -> FETCH.
  - jr (op 0, func 001000): PCWrite, PCSrc=11, Retire -> FETCH.
  - lui: RegWrite, RegDst=00, WBSrc=10, Retire -> FETCH.
  - nop (op 0, func 000000) and any unlisted op/func: no strobes, Retire -> FETCH (illegal = nop).
  - add/sub/ori/lw/sw/beq -> EXEC.
- EXEC:
  - beq: ALUop=001, PCWrite=Zero, PCSrc=01, Retire -> FETCH.
  - add/sub/ori -> WB.
  - lw/sw -> MEM.
- MEM:
  - MemReq=1, IorD=1, MemWe=(op==sw).
  - Hold while MemAck=0.
  - On ack: sw gives Retire -> FETCH; lw -> WB (datapath latches MDR on the ack cycle).
- WB:
  - RegWrite=1, Retire -> FETCH.
  - add/sub: RegDst=01, WBSrc=00.
  - ori: RegDst=00, WBSrc=00.
  - lw: RegDst=00, WBSrc=01.
- ALU controls (decoded from op/func in every state; consumers use them only in EXEC/MEM/WB):
  - ALUop: sub/beq = 001, ori = 011, otherwise 000.
  - ALUsrc=1 for ori/lw/sw.
  - ExtRes=1 for ori only.
- Handshake: MemAck while MemReq=0 is ignored. MemReq, IorD and MemWe stay constant until the ack cycle.
- InstrCnt increments by 1 on each edge where Retire=1 and wraps modulo 2^32.
- PCWrite and RegWrite are never asserted in the same cycle except for jal.

## Timing
- Outputs are combinational from the registered state plus op/func/Zero/MemAck; they are not registered.
- The state register and InstrCnt update on the rising edge or on async reset.
- First MemReq is in the second cycle after reset_n rises (IDLE takes one cycle).
- Cycles per instruction with zero-wait memory (MemAck high on the request cycle): nop/jr/jal/lui 2, beq 3, add/sub/ori/sw 4, lw 5. Each memory wait cycle adds one.
- IRWrite and PCWrite(PC+4) assert only in the FETCH ack cycle; IR is valid from DECODE.
- Retire and the corresponding InstrCnt increment are visible in the cycle after the edge.

## Test plan
- Reset, zero-wait memory, program `ori $1,$0,0x00ff`: cycles 1–4 show FETCH (IRWrite), DECODE, EXEC (ALUsrc=1, ExtRes=1, ALUop=011), WB (RegWrite=1, RegDst=00, WBSrc=00). InstrCnt goes 0→1.
- `lw` with MemAck delayed 3 cycles in MEM: MemReq=1, IorD=1, MemWe=0 held for 4 cycles. Next cycle is WB with WBSrc=01. Total 8 cycles.
- `beq` with Zero=1 and with Zero=0: PCWrite=1/0 respectively, PCSrc=01, Retire in EXEC. Total 3 cycles each.
- `jal` then `jr $31`: jal in DECODE gives PCWrite, PCSrc=10, RegWrite, RegDst=10, WBSrc=11. jr gives PCSrc=11. Each takes 2 cycles.
- Illegal op 6'b111111: treated as nop, 2 cycles, Retire=1, no RegWrite/PCWrite/MemReq after fetch.
- reset_n pulsed low mid-MEM of `sw`: MemReq drops to 0 asynchronously, InstrCnt=0, state restarts at IDLE→FETCH.
